// File: rtl/ud_ctrl_pkg.sv
// Shared types, defaults and helpers for the up/down count controller.
package ud_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 3;
    localparam int unsigned DEF_DIV   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Distance travelled going up from 'from' to 'to' on a ring of 2^width values.
    function automatic logic [31:0] ring_dist(input logic [31:0] from,
                                              input logic [31:0] to,
                                              input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (to - from) & mask;
    endfunction

endpackage

// File: rtl/ud_step_counter.sv
// WIDTH-bit JK-style up/down counter with enable and synchronous active-low reset.
module ud_step_counter
    import ud_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ud,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] jk;
    logic [WIDTH-1:0] q_nx;

    // Bit i toggles (J = K = 1) when all lower bits are 1 counting up, or 0 counting down.
    always_comb begin : toggle_chain
        logic carry;
        jk    = '0;
        carry = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            jk[i] = en & carry;
            carry = carry & (ud ? q[i] : ~q[i]);
        end
        q_nx = (jk & ~q) | (~jk & q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_nx;
        end
    end

endmodule

// File: rtl/ud_count_ctrl.sv
// Move-to-target sequencer for the up/down counter: direction select, prescaled stepping, done pulse.
// Option macro UD_CTRL_SHORTEST_PATH_EN: choose direction by shortest ring distance instead of dir_in.
module ud_count_ctrl
    import ud_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DIV   = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic             dir_in,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             ud,
    output logic             step,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    state_e           state, state_nx;
    logic [PW-1:0]    presc, presc_nx;
    logic [WIDTH-1:0] tgt, tgt_nx;
    logic             ud_nx, step_nx, busy_nx, done_nx;
    logic             dir_pick_c;
    logic             cnt_en_c;
    logic [WIDTH-1:0] count_stepped_c;

`ifdef UD_CTRL_SHORTEST_PATH_EN
    logic [WIDTH-1:0] up_dist_c, dn_dist_c;
    logic             unused_dir_in;

    assign up_dist_c     = WIDTH'(ring_dist(32'(count), 32'(target), WIDTH));
    assign dn_dist_c     = WIDTH'(ring_dist(32'(target), 32'(count), WIDTH));
    assign dir_pick_c    = (up_dist_c <= dn_dist_c);
    assign unused_dir_in = dir_in;
`else
    assign dir_pick_c = dir_in;
`endif

    // A step that coincides with abort never reaches the counter.
    assign cnt_en_c        = step & ~abort;
    assign count_stepped_c = ud ? (count + WIDTH'(1)) : (count - WIDTH'(1));

    ud_step_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en_c),
        .ud    (ud),
        .q     (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            presc <= '0;
            tgt   <= '0;
            ud    <= 1'b1;
            step  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            presc <= presc_nx;
            tgt   <= tgt_nx;
            ud    <= ud_nx;
            step  <= step_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    // Next state; registered outputs are decoded from the next state so they line up with it.
    always_comb begin
        state_nx = state;
        presc_nx = presc;
        tgt_nx   = tgt;
        ud_nx    = ud;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    tgt_nx   = target;
                    ud_nx    = dir_pick_c;
                    presc_nx = '0;
                    state_nx = (target == count) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    presc_nx = '0;
                    state_nx = IDLE;
                end else if (step) begin
                    presc_nx = '0;
                    if (count_stepped_c == tgt) begin
                        state_nx = DONE;
                    end
                end else begin
                    presc_nx = presc + PW'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        step_nx = (state_nx == RUN) && (presc_nx == PRESC_LAST);
        busy_nx = (state_nx == RUN);
        done_nx = (state_nx == DONE);
    end

endmodule
